top: RTL and testbench
======================

# top

UART top-level block: an 8N1 serial receiver plus transmitter on a single system clock. It deserializes frames arriving on `Rx`, presents the last good byte on `RxData`, and optionally echoes each received byte back out on `Tx`. It is the board-level UART endpoint, driven directly from the pins.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud); legal range ≥ 8.
- `Clk`, input, 1: system clock, 50 MHz (20 ns period).
- `Rst_n`, input, 1: reset. Synchronous and active-high despite the name; `Rst_n`=1 at a `Clk` rising edge resets the block.
- `Rx`, input, 1: serial input, asynchronous, idle high.
- `Tx`, output, 1: serial output, registered, idle high.
- `RxData`, output, 8: last correctly framed received byte, registered.

## Operation
- `Rx` passes through a 2-flop synchronizer before use.
- Receiver FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: a synchronized low moves to `START`, with the bit counter cleared.
  - `START`: sample at cycle `CLKS_PER_BIT/2`. If low, go to `DATA`. If high, treat as a glitch and return to `IDLE`.
  - `DATA`: sample every `CLKS_PER_BIT` cycles from the start-bit center. Receive 8 bits, LSB first, into a shift register.
  - `STOP`: sample one bit period later. If high, load the shift register into `RxData` and pulse internal `rx_valid` for 1 cycle. If low (framing error), discard the byte and leave `RxData` unchanged. In both cases return to `IDLE`.
- Transmitter FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - Each state holds for exactly `CLKS_PER_BIT` cycles.
  - `Tx` drives 0 (start), then data bits LSB first, then 1 (stop), then returns to `IDLE` with `Tx`=1.
- Echo path (see Configuration):
  - On `rx_valid`, if the transmitter is idle, it loads the byte and starts immediately.
  - If the transmitter is busy, the byte goes into a 1-entry pending register. It is sent as soon as the transmitter returns to `IDLE`.
  - A new `rx_valid` while the pending register is full overwrites it; the newest byte wins.
- Reset mid-frame:
  - Both FSMs return to `IDLE` and the pending flag clears.
  - `Tx` goes to 1 and `RxData` to 8'h00 on the reset edge.
  - A partially received byte is lost.

## Timing
- Reset values: `Tx`=1, `RxData`=8'h00; FSMs in `IDLE`; counters 0; pending empty.
- Pin-to-detect latency is 2 cycles (synchronizer).
- `RxData` updates on the edge that takes the stop-bit sample, i.e. about 9.5 bit periods plus 2–3 cycles after the `Rx` falling edge.
- `Tx` falls (start bit) on the edge after `rx_valid` when the transmitter is idle.
- A transmitted frame is exactly `10*CLKS_PER_BIT` cycles.
- Bit counters are ceil(log2(`CLKS_PER_BIT`)) bits wide and wrap to 0 at `CLKS_PER_BIT-1`.
- Continuous back-to-back input frames are accepted with no loss. The receiver is back in `IDLE` at the stop-bit center.
- Simultaneous `rx_valid` and transmitter completion on the same edge: the new byte starts directly and the pending register is left untouched.

## Configuration
- `UART_ECHO_EN`
  - Defined: echo path as described; every good received byte is retransmitted on `Tx`.
  - Undefined: the transmitter and pending register are not built, and `Tx` is tied to 1. The receiver and `RxData` behave identically in both builds.

## Test plan
- Reset: hold `Rst_n`=1 for 2 edges with `Rx`=1 → `RxData`=8'h00, `Tx`=1, and `Tx` stays 1 for 10 bit periods after release.
- Receive 0xA5 at 8680 ns/bit (bits 0,1,0,1,0,0,1,0,1,1) → `RxData`=8'hA5 about 9.5 bit periods later. With echo enabled, `Tx` emits the same 10-bit frame with each bit lasting exactly 434 cycles.
- Glitch: pull `Rx` low for 100 cycles, then high → `RxData` unchanged and `Tx` stays 1.
- Framing error: send 0x3C with stop bit 0 after a good 0x11 → `RxData` remains 8'h11 and no echo is produced for 0x3C.
- Back-to-back 0x55 then 0xAA with no idle gap → `RxData` shows 8'h55 then 8'hAA, and `Tx` echoes 0x55 then 0xAA in order.
- Reset mid-frame: assert `Rst_n` during data bit 3 of 0xF0 → `RxData`=8'h00, `Tx`=1. A following 0x0F frame is then received correctly.

Source files
------------

// File: rtl/top.sv
// top: 8N1 UART receiver with optional echo transmitter (echo built only when UART_ECHO_EN is defined).
// Latency: RxData updates at the stop-bit sample (~9.5 bits + 2-3 clks after Rx falls); echo Tx starts the edge after rx_valid.
// Backpressure: none, pins cannot stall; a 1-entry pending register holds one echo byte while Tx is busy (newest wins).
module top #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rx,
  output logic       Tx,
  output logic [7:0] RxData
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------
  logic          rx_meta_q;
  logic          rx_sync_q;
  state_t        rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;

  // Two-flop synchronizer for the asynchronous pin; idles high so reset must not fake a start bit.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM: validate start at half bit, then sample data/stop at bit centers.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          if (!rx_sync_q) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            // A line already back high at mid start bit is a glitch.
            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            // Low stop bit is a framing error: keep the previous byte.
            if (rx_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign RxData = rx_data_q;

`ifdef UART_ECHO_EN
  // ---------------------------------------------------------------
  // Echo transmitter
  // ---------------------------------------------------------------
  state_t        tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic          pend_vld_q;
  logic [7:0]    pend_dat_q;
  logic          tx_done;

  // Last cycle of the stop bit: a new byte arriving now goes straight out instead of to pending.
  assign tx_done = (tx_state_q == S_STOP) && (tx_cnt_q == CNT_LAST);

  // Transmit FSM plus pending register; every state lasts exactly one bit period.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
    end else begin
      if (rx_valid_q && (tx_state_q != S_IDLE) && !tx_done) begin
        pend_vld_q <= 1'b1;
        pend_dat_q <= rx_data_q;
      end
      case (tx_state_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          tx_q     <= 1'b1;
          if (rx_valid_q) begin
            tx_shift_q <= rx_data_q;
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_q <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            if (rx_valid_q) begin
              tx_shift_q <= rx_data_q;
              tx_q       <= 1'b0;
              tx_state_q <= S_START;
            end else if (pend_vld_q) begin
              tx_shift_q <= pend_dat_q;
              pend_vld_q <= 1'b0;
              tx_q       <= 1'b0;
              tx_state_q <= S_START;
            end else begin
              tx_q       <= 1'b1;
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign Tx = tx_q;
`else
  // No echo path: line idles permanently; rx_valid has no consumer.
  logic unused_rx_valid;
  assign unused_rx_valid = rx_valid_q;
  assign Tx = 1'b1;
`endif

endmodule

// File: tb/tb_top.sv
// Scoreboarded bench for the UART top: random and directed frames at 16 clks/bit.
// Expected bytes are queued at stimulus time; Rx and Tx monitors pop and compare.
// Tx frames are checked bit-by-bit for exact duration.
module tb_top;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       tx;
  logic [7:0] rx_data;

  top #(.CLKS_PER_BIT(CPB)) dut (
    .Clk    (clk),
    .Rst_n  (rst),
    .Rx     (rx),
    .Tx     (tx),
    .RxData (rx_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] exp_last;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, want %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Full 8N1 frame; only a high stop bit makes a byte the UART should deliver/echo.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    if (stop) begin
      rxq.push_back(b);
`ifdef UART_ECHO_EN
      txq.push_back(b);
`endif
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rx = stop;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  // Rx monitor: each rx_valid strobe must deliver the oldest outstanding good byte.
  initial begin : rx_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (dut.rx_valid_q === 1'b1) begin
        if (rxq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected_valid: got %02h, want no byte (t=%0t)", rx_data, $time);
        end else begin
          e = rxq.pop_front();
          check("rx_byte", rx_data, e);
        end
      end
    end
  end

  // Tx monitor: every start bit must begin the next expected echo frame, each bit exactly CPB clks.
  initial begin : tx_mon
    logic [9:0] fr;
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (tx !== 1'b1) begin
        if (txq.size() == 0) begin
          check("tx_unexpected_start", {7'd0, tx}, 8'd1);
          repeat (10 * CPB) @(negedge clk);
        end else begin
          b  = txq.pop_front();
          fr = {1'b1, b, 1'b0};
          for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
              if (!(k == 0 && c == 0)) @(negedge clk);
              if (tx !== fr[k]) ok = 1'b0;
            end
            check($sformatf("tx_b%02h_bit%0d", b, k), {7'd0, ok}, 8'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    logic [7:0] f0;
    logic       tx_ok;
    rst = 1'b1;
    rx  = 1'b1;
    exp_last = 8'h00;

    // Reset: two edges, then Tx must idle for ten bit periods.
    repeat (2) @(negedge clk);
    check("rst_rxdata", rx_data, 8'h00);
    check("rst_tx", {7'd0, tx}, 8'd1);
    rst = 1'b0;
    tx_ok = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_ok = 1'b0;
    end
    check("post_rst_tx_idle", {7'd0, tx_ok}, 8'd1);

    // Single frame 0xA5.
    send_frame(8'hA5, 1'b1, CPB); exp_last = 8'hA5;
    idle(12 * CPB);
    check("a5_rxdata", rx_data, exp_last);

    // Short glitches shorter than half a bit must be ignored.
    for (int g = 0; g < 3; g++) begin
      rx = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      idle(2 * CPB);
      check("glitch_rxdata", rx_data, exp_last);
      check("glitch_tx", {7'd0, tx}, 8'd1);
    end

    // Good 0x11 then 0x3C with a low stop bit.
    send_frame(8'h11, 1'b1, CPB); exp_last = 8'h11;
    idle(2 * CPB);
    send_frame(8'h3C, 1'b0, CPB);
    idle(12 * CPB);
    check("frame_err_rxdata", rx_data, exp_last);

    // Back-to-back 0x55, 0xAA.
    send_frame(8'h55, 1'b1, CPB);
    send_frame(8'hAA, 1'b1, CPB); exp_last = 8'hAA;
    idle(12 * CPB);
    check("b2b_rxdata", rx_data, exp_last);

    // Shortened stop bits: input outruns the echo, forcing use of the pending register.
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 12); exp_last = b;
    end
    idle(15 * CPB);
    check("short_stop_rxdata", rx_data, exp_last);

    // Random traffic with occasional framing errors.
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(b, 1'b0, CPB);
        idle(CPB + int'($urandom_range(0, 16)));
      end else begin
        send_frame(b, 1'b1, CPB); exp_last = b;
        idle(int'($urandom_range(0, 40)));
      end
    end
    idle(12 * CPB);
    check("random_rxdata", rx_data, exp_last);

    // Reset during data bit 3 of 0xF0, then a clean 0x0F.
    f0 = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(f0[i]);
    rx = f0[3];
    repeat (CPB / 2) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_rxdata", rx_data, 8'h00);
    check("mid_rst_tx", {7'd0, tx}, 8'd1);
    rst = 1'b0;
    exp_last = 8'h00;
    idle(2 * CPB);
    check("after_rst_rxdata", rx_data, 8'h00);
    check("after_rst_tx", {7'd0, tx}, 8'd1);
    send_frame(8'h0F, 1'b1, CPB); exp_last = 8'h0F;
    idle(15 * CPB);
    check("post_rst_0f_rxdata", rx_data, exp_last);

    // Everything queued must have been delivered and echoed.
    check("rxq_drained", 8'(rxq.size()), 8'd0);
    check("txq_drained", 8'(txq.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
